// File: rtl/dmem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit_if
// Brief    : Single-outstanding req/ack data-memory bus between the M-stage
//            access unit (master) and the data memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit
// Brief    : RV32I memory-stage load/store controller: issues one bus
//            transaction per access, formats loads and stalls via Ready.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              MemReadM,
  input  wire logic              MemWriteM,
  input  wire logic [ADDR_W-1:0] ALUResultM,
  input  wire logic [31:0]       WriteDataM,
  input  wire logic [2:0]        funct3M,
  output logic                   Ready,
  output logic [31:0]            ReadDataM,
  output logic                   AccessFaultM,
  dmem_access_unit_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_access;
  logic              w_fault;
  logic              w_start;
  logic              w_is_half;
  logic              w_is_word;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [2:0]        r_funct3;
  logic [1:0]        r_lane;
  logic [31:0]       r_rdata;

  // Access decode for the instruction currently sitting in M.
  always_comb begin
    w_access  = MemReadM | MemWriteM;
    w_lane    = ALUResultM[1:0];
    w_is_half = (funct3M[1:0] == 2'b01);
    w_is_word = (funct3M[1:0] == 2'b10);
    w_fault   = (MemReadM & MemWriteM)
              | (funct3M == 3'b011)
              | (funct3M[2:1] == 2'b11)
              | (MemWriteM & (funct3M == 3'b100))
              | (w_is_half & ALUResultM[0])
              | (w_is_word & (|ALUResultM[1:0]));
    case (funct3M[1:0])
      2'b00:   begin w_be = 4'b0001 << w_lane; w_wdata = {4{WriteDataM[7:0]}};  end
      2'b01:   begin w_be = 4'b0011 << w_lane; w_wdata = {2{WriteDataM[15:0]}}; end
      default: begin w_be = 4'b1111;           w_wdata = WriteDataM;            end
    endcase
  end

  // Lane selection uses the address captured at issue, not the live M inputs.
  always_comb begin
    w_byte = bus.mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = bus.mem_rdata[{r_lane[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    Ready        = 1'b0;
    AccessFaultM = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_access) begin
          Ready = 1'b1;
        end else if (w_fault) begin
          Ready        = 1'b1;
          AccessFaultM = 1'b1;
        end else begin
          w_start = 1'b1;
          w_next  = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          w_next = DONE;
        end
      end
      DONE: begin
        Ready  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset must release the pipeline even while an access is presented.
    if (!rst) begin
      Ready        = 1'b1;
      AccessFaultM = 1'b0;
      w_start      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_be     <= 4'd0;
      r_funct3 <= 3'd0;
      r_lane   <= 2'd0;
      r_rdata  <= 32'd0;
    end else if (w_start) begin
      r_req    <= 1'b1;
      r_we     <= MemWriteM;
      r_addr   <= {ALUResultM[ADDR_W-1:2], 2'b00};
      r_wdata  <= w_wdata;
      r_be     <= w_be;
      r_funct3 <= funct3M;
      r_lane   <= w_lane;
    end else if ((r_state == BUSY) && bus.mem_ack) begin
      r_req    <= 1'b0;
      r_rdata  <= w_load;
    end
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;
  assign ReadDataM     = AccessFaultM ? 32'd0 : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_unit
// Brief    : Randomized scoreboard bench for dmem_access_unit with a
//            latency-randomizing memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  funct3M;
  logic        Ready, AccessFaultM;
  logic [31:0] ReadDataM;

  dmem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .funct3M      (funct3M),
    .Ready        (Ready),
    .ReadDataM    (ReadDataM),
    .AccessFaultM (AccessFaultM),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; int gap; } req_t;
  typedef struct packed { logic fault; logic load; logic [31:0] rdata; int low; } done_t;
  typedef struct packed { int w; logic [31:0] rdata; } mem_t;

  req_t  exp_req[$];
  done_t exp_done[$];
  mem_t  mem_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    prev_valid = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules for an RV32I data access.
  function automatic bit m_fault(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    bit f = rd && wr;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f = 1'b1;
    if (wr && f3 == 3'd4) f = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) f = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'd0) f = 1'b1;
    return f;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [1:0] lane);
    int n = (f3 == 3'd2) ? 4 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wd);
    if (f3 == 3'd0) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (f3 == 3'd1) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [1:0] lane, logic [31:0] rd);
    logic [31:0] v = rd >> (8 * lane);
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd4:    return {24'd0, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return rd;
    endcase
  endfunction

  // Present one M-stage access, hold it until Ready, then advance the pipeline.
  task automatic access(bit rd, bit wr, logic [2:0] f3, logic [31:0] a,
                        logic [31:0] wd, logic [31:0] rdat, int w);
    bit    f;
    req_t  r;
    done_t d;
    mem_t  m;
    int    n;
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    f       = m_fault(rd, wr, f3, a);
    d.fault = f;
    d.load  = rd && !f;
    d.rdata = f ? 32'd0 : m_load(f3, a[1:0], rdat);
    d.low   = f ? 0 : 2 + w;
    exp_done.push_back(d);
    if (!f) begin
      r.addr  = {a[31:2], 2'b00};
      r.we    = wr;
      r.be    = m_be(f3, a[1:0]);
      r.wdata = m_wdata(f3, wd);
      r.gap   = prev_valid ? 2 : -1;
      exp_req.push_back(r);
      m.w     = w;
      m.rdata = rdat;
      mem_q.push_back(m);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Ready && n < 200);
    if (!Ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: Ready still 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    prev_valid = !f;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    prev_valid = 1'b0;
  endtask

  // Memory model: acks after a chosen number of wait cycles.
  initial begin
    mem_t m;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst && bus.mem_req && mem_q.size() > 0) begin
        m = mem_q.pop_front();
        repeat (m.w) @(negedge clk);
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = m.rdata;
        @(negedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: request side and completion side scoreboards.
  int          cyc = 0;
  int          low_cnt = 0;
  int          last_done_cyc = -100;
  bit          req_prev = 1'b0;
  bit          cur_ok = 1'b0;
  bit          hold = 1'b1;
  logic [31:0] last_rd = 32'd0;
  req_t        cur;
  done_t       dn;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      req_prev = 1'b0;
      low_cnt  = 0;
      hold     = 1'b1;
      last_rd  = 32'd0;
    end else begin
      if (bus.mem_ack) begin
        check("req_after_ack", {31'd0, bus.mem_req}, 32'd0);
        check("ready_after_ack", {31'd0, Ready}, 32'd1);
      end
      if (bus.mem_req && !req_prev) begin
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          cur_ok = 1'b0;
          $display("FAIL unexpected_req: got request addr %h, required no request", bus.mem_addr);
        end else begin
          cur    = exp_req.pop_front();
          cur_ok = 1'b1;
          check("req_addr", bus.mem_addr, cur.addr);
          check("req_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
          check("req_be", {28'd0, bus.mem_be}, {28'd0, cur.be});
          if (cur.we) check("req_wdata", bus.mem_wdata, cur.wdata);
          if (cur.gap >= 0) check("req_gap", cyc - last_done_cyc, cur.gap);
        end
      end else if (bus.mem_req && cur_ok) begin
        check("hold_addr", bus.mem_addr, cur.addr);
        check("hold_be", {28'd0, bus.mem_be}, {28'd0, cur.be});
        check("hold_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
        if (cur.we) check("hold_wdata", bus.mem_wdata, cur.wdata);
      end
      req_prev = bus.mem_req;

      if (!(MemReadM | MemWriteM)) begin
        check("ready_no_access", {31'd0, Ready}, 32'd1);
        check("fault_no_access", {31'd0, AccessFaultM}, 32'd0);
        if (hold) check("rdata_idle_hold", ReadDataM, last_rd);
        low_cnt = 0;
      end else if (!Ready) begin
        low_cnt++;
        check("fault_while_stalled", {31'd0, AccessFaultM}, 32'd0);
        if (hold) check("rdata_stall_hold", ReadDataM, last_rd);
      end else if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Ready=1 with access, required no completion");
      end else begin
        dn = exp_done.pop_front();
        check("fault", {31'd0, AccessFaultM}, {31'd0, dn.fault});
        check("ready_low_cycles", low_cnt, dn.low);
        if (dn.fault)     check("fault_rdata", ReadDataM, 32'd0);
        else if (dn.load) check("load_data", ReadDataM, dn.rdata);
        if (!dn.fault) last_done_cyc = cyc;
        hold    = dn.load;
        last_rd = dn.rdata;
        low_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic [2:0]  st_f3 [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  int          k;
  logic [31:0] a;
  req_t        rr;
  mem_t        mm;

  initial begin
    rst = 1'b0;
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2;
    ALUResultM = 32'h100; WriteDataM = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", {31'd0, Ready}, 32'd1);
      check("rst_fault", {31'd0, AccessFaultM}, 32'd0);
      check("rst_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_rdata", ReadDataM, 32'd0);
      check("rst_addr", bus.mem_addr, 32'd0);
      check("rst_be", {28'd0, bus.mem_be}, 32'd0);
    end
    #2;
    MemReadM = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    access(1, 0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0);
    access(1, 0, 3'd0, 32'h203, 32'd0, 32'h80FF_7F01, 3);
    access(1, 0, 3'd4, 32'h203, 32'd0, 32'h80FF_7F01, 3);
    access(0, 1, 3'd1, 32'h102, 32'h1234_ABCD, 32'd0, 1);
    idle(1);
    access(1, 0, 3'd2, 32'h102, 32'd0, 32'd0, 0);
    access(0, 1, 3'd1, 32'h101, 32'h5555_AAAA, 32'd0, 0);
    access(1, 0, 3'd3, 32'h0, 32'd0, 32'd0, 0);
    access(1, 1, 3'd2, 32'h100, 32'd0, 32'd0, 0);
    idle(2);
    access(1, 0, 3'd1, 32'h202, 32'd0, 32'h8001_7FFF, 1);
    access(1, 0, 3'd5, 32'h202, 32'd0, 32'h8001_7FFF, 2);
    idle(1);

    // Abandon a transaction mid-BUSY; its late ack must be ignored.
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2; ALUResultM = 32'h40;
    rr.addr = 32'h40; rr.we = 1'b0; rr.be = 4'hF; rr.wdata = 32'd0; rr.gap = -1;
    exp_req.push_back(rr);
    mm.w = 6; mm.rdata = 32'hCAFE_F00D;
    mem_q.push_back(mm);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("async_rst_ready", {31'd0, Ready}, 32'd1);
    check("async_rst_fault", {31'd0, AccessFaultM}, 32'd0);
    MemReadM = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("stale_ack_req", {31'd0, bus.mem_req}, 32'd0);
      check("stale_ack_ready", {31'd0, Ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    prev_valid = 1'b0;

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'd0;
      if (k == 0) begin
        idle($urandom_range(1, 2));
      end else if (k == 1) begin
        access(1, 1, 3'($urandom_range(0, 7)), a, $urandom, $urandom, 0);
      end else if (k < 6) begin
        access(1, 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(0, 3));
      end else begin
        access(0, 1, st_f3[$urandom_range(0, 6)], a, $urandom, $urandom, $urandom_range(0, 3));
      end
    end

    idle(10);
    check("req_queue_drained", exp_req.size(), 32'd0);
    check("done_queue_drained", exp_done.size(), 32'd0);
    check("mem_queue_drained", mem_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
